// File: rtl/pad_config_serializer.sv
// Serial loader for the user pad configuration chain: fetches one word per pad,
// shifts every word MSB-first down the daisy chain, then strobes a parallel load.
module pad_config_serializer #(
    parameter int NUM_PADS = 38,
    parameter int CFG_BITS = 13,
    parameter int CLK_DIV  = 2,
    parameter int IDX_W    = (NUM_PADS > 1) ? $clog2(NUM_PADS) : 1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic                abort,
    output logic [IDX_W-1:0]    cfg_index,
    input  logic [CFG_BITS-1:0] cfg_data,
    output logic                busy,
    output logic                done,
    output logic                serial_clock,
    output logic                serial_data,
    output logic                serial_load
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BIT_W = (CFG_BITS > 1) ? $clog2(CFG_BITS) : 1;

    typedef enum logic [2:0] {IDLE, FETCH, SHIFT_LO, SHIFT_HI, LOAD} state_t;

    state_t              state, state_n;
    logic [DIV_W-1:0]    div_cnt, div_n;
    logic [BIT_W-1:0]    bit_cnt, bit_n;
    logic [IDX_W-1:0]    idx_n;
    logic [CFG_BITS-1:0] shreg, shreg_n;
    logic                done_n;
    logic                div_last;

    assign div_last = (div_cnt == DIV_W'(CLK_DIV - 1));

    always_comb begin
        state_n = state;
        div_n   = div_cnt;
        bit_n   = bit_cnt;
        idx_n   = cfg_index;
        shreg_n = shreg;
        done_n  = 1'b0;
        case (state)
            IDLE: begin
                if (start && !abort) begin
                    idx_n   = IDX_W'(NUM_PADS - 1);
                    bit_n   = BIT_W'(CFG_BITS - 1);
                    div_n   = '0;
                    state_n = FETCH;
                end
            end
            FETCH: begin
                shreg_n = cfg_data;
                div_n   = '0;
                state_n = SHIFT_LO;
            end
            SHIFT_LO: begin
                if (div_last) begin
                    div_n   = '0;
                    state_n = SHIFT_HI;
                end else begin
                    div_n = div_cnt + DIV_W'(1);
                end
            end
            SHIFT_HI: begin
                if (div_last) begin
                    div_n   = '0;
                    shreg_n = shreg << 1;
                    if (bit_cnt != '0) begin
                        bit_n   = bit_cnt - BIT_W'(1);
                        state_n = SHIFT_LO;
                    end else if (cfg_index != '0) begin
                        idx_n   = cfg_index - IDX_W'(1);
                        bit_n   = BIT_W'(CFG_BITS - 1);
                        state_n = FETCH;
                    end else begin
                        state_n = LOAD;
                    end
                end else begin
                    div_n = div_cnt + DIV_W'(1);
                end
            end
            LOAD: begin
                if (div_last) begin
                    div_n   = '0;
                    done_n  = 1'b1;
                    state_n = IDLE;
                end else begin
                    div_n = div_cnt + DIV_W'(1);
                end
            end
            default: state_n = IDLE;
        endcase
        // Cancel drops straight to idle without a load strobe, so pads keep their old config.
        if (abort && state != IDLE) begin
            state_n = IDLE;
            idx_n   = '0;
            div_n   = '0;
            bit_n   = '0;
            done_n  = 1'b0;
        end
    end

    // Outputs are registered from the next-state view so they line up with state.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            div_cnt      <= '0;
            bit_cnt      <= '0;
            shreg        <= '0;
            cfg_index    <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            serial_clock <= 1'b0;
            serial_data  <= 1'b0;
            serial_load  <= 1'b0;
        end else begin
            state        <= state_n;
            div_cnt      <= div_n;
            bit_cnt      <= bit_n;
            shreg        <= shreg_n;
            cfg_index    <= idx_n;
            busy         <= (state_n != IDLE);
            done         <= done_n;
            serial_clock <= (state_n == SHIFT_HI);
            serial_load  <= (state_n == LOAD);
            serial_data  <= ((state_n == SHIFT_LO) || (state_n == SHIFT_HI)) && shreg_n[CFG_BITS-1];
        end
    end

endmodule
